// File: rtl/led_status_sequencer.sv
// led_status_sequencer: stretched event flashes, power-up sweep, idle heartbeat and lamp test on 4 active-low LEDs.
// Latency: event_in rising in cycle N lights leds[i] from cycle N+2; leds, bnc and sweep_done are registered.
// Backpressure: none, event_in is sampled every cycle; define LED_STATUS_BNC_MIRROR_EN to mirror activity onto bnc.
module led_status_sequencer #(
  parameter int TICK_DIV      = 100000,
  parameter int STRETCH_TICKS = 50,
  parameter int HB_TICKS      = 500,
  parameter int SWEEP_TICKS   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] event_in,
  input  logic       test_en,
  output logic [3:0] leds,
  output logic [3:0] bnc,
  output logic [3:0] gnd,
  output logic       sweep_done
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STRETCH_TICKS + 1);
  localparam int HW = $clog2(HB_TICKS + 1);
  localparam int PW = $clog2(SWEEP_TICKS + 1);

  localparam logic [DW-1:0] DIV_LAST     = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);
  localparam logic [HW-1:0] HB_LAST      = HW'(HB_TICKS - 1);
  localparam logic [PW-1:0] SWEEP_LAST   = PW'(SWEEP_TICKS - 1);

  typedef enum logic [1:0] {
    SWEEP = 2'd0,
    RUN   = 2'd1,
    TEST  = 2'd2
  } state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    event_q;
  logic [3:0]    evt_edge;
  logic [SW-1:0] cnt [4];
  logic [3:0]    act;
  logic [HW-1:0] hb_cnt;
  logic          hb;
  state_t        state;
  logic [3:0]    sweep_lit;
  logic [PW-1:0] sweep_cnt;
  logic [3:0]    lit;

  assign gnd = 4'h0;

  // Free-running prescaler; tick marks the last cycle of each period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // One-cycle delayed copy of event_in for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_q <= 4'h0;
    end else begin
      event_q <= event_in;
    end
  end

  assign evt_edge = event_in & ~event_q;

  // Per-channel stretch: an edge (re)loads, ticks drain; a load beats a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (evt_edge[i]) begin
          cnt[i] <= STRETCH_LOAD;
        end else if (tick && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  // Channel activity is simply a nonzero stretch count.
  always_comb begin
    act = 4'h0;
    for (int i = 0; i < 4; i++) act[i] = (cnt[i] != '0);
  end

  // Heartbeat toggles every HB_TICKS ticks regardless of mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb     <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt <= '0;
        hb     <= ~hb;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // LED pattern for the current mode; heartbeat only shows when all channels are idle.
  always_comb begin
    lit = sweep_lit;
    case (state)
      RUN:     lit = {act[3:1], act[0] | (hb & ~|act)};
      TEST:    lit = 4'hF;
      default: lit = sweep_lit;
    endcase
  end

  // Mode FSM with registered LED drive; lamp test overrides and aborts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SWEEP;
      sweep_lit  <= 4'b0001;
      sweep_cnt  <= '0;
      sweep_done <= 1'b0;
      leds       <= 4'hF;
    end else begin
      leds <= ~lit;
      case (state)
        SWEEP: begin
          if (test_en) begin
            state      <= TEST;
            sweep_done <= 1'b1;
          end else if (tick) begin
            if (sweep_cnt == SWEEP_LAST) begin
              sweep_cnt <= '0;
              if (sweep_lit[3]) begin
                state      <= RUN;
                sweep_done <= 1'b1;
              end else begin
                sweep_lit <= {sweep_lit[2:0], 1'b0};
              end
            end else begin
              sweep_cnt <= sweep_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (test_en) begin
            state      <= TEST;
            sweep_done <= 1'b1;
          end
        end
        TEST: begin
          if (!test_en) state <= RUN;
        end
        default: state <= SWEEP;
      endcase
    end
  end

`ifdef LED_STATUS_BNC_MIRROR_EN
  // Raw stretched activity on the BNCs, aligned with the LED register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnc <= 4'h0;
    end else begin
      bnc <= act;
    end
  end
`else
  assign bnc = 4'h0;
`endif

endmodule

// File: tb/tb_led_status_sequencer.sv
// tb_led_status_sequencer: scoreboard bench for led_status_sequencer with small timing parameters.
// Expected output values are queued with their cycle number when stimulus is applied.
// A negedge monitor pops entries whose cycle has arrived and compares them against the DUT.
module tb_led_status_sequencer;

  localparam int F_LEDS = 0;
  localparam int F_BNC  = 1;
  localparam int F_GND  = 2;
  localparam int F_DONE = 3;

`ifdef LED_STATUS_BNC_MIRROR_EN
  localparam logic [3:0] BNC_MASK = 4'hF;
`else
  localparam logic [3:0] BNC_MASK = 4'h0;
`endif

  typedef struct {
    int         cyc;
    int         fld;
    logic [3:0] val;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] event_in = 4'h0;
  logic       test_en = 1'b0;
  logic [3:0] leds;
  logic [3:0] bnc;
  logic [3:0] gnd;
  logic       sweep_done;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  logic [3:0] mon_got;

  led_status_sequencer #(
    .TICK_DIV      (4),
    .STRETCH_TICKS (3),
    .HB_TICKS      (5),
    .SWEEP_TICKS   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .event_in   (event_in),
    .test_en    (test_en),
    .leds       (leds),
    .bnc        (bnc),
    .gnd        (gnd),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int c, input int f, input logic [3:0] v, input string t);
    exp_t e;
    e.cyc = c;
    e.fld = f;
    e.val = v;
    e.tag = $sformatf("%s@%0d", t, c);
    sb.push_back(e);
  endtask

  function automatic logic [3:0] bx(input logic [3:0] v);
    return v & BNC_MASK;
  endfunction

  // Advance to the start of cycle n (just after its rising edge).
  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk($sformatf("goto_%0d", n), cyc, n);
  endtask

  // Scoreboard monitor: compare every entry scheduled for this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].fld)
            F_LEDS:  mon_got = leds;
            F_BNC:   mon_got = bnc;
            F_GND:   mon_got = gnd;
            default: mon_got = {3'b000, sweep_done};
          endcase
          chk(sb[i].tag, {28'h0, mon_got}, {28'h0, sb[i].val});
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while held in reset.
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_leds", {28'h0, leds}, 32'hF);
    chk("rst_bnc", {28'h0, bnc}, 32'h0);
    chk("rst_gnd", {28'h0, gnd}, 32'h0);
    chk("rst_done", {31'h0, sweep_done}, 32'h0);

    // Power-up sweep: E, D, B, 7 at 8 clk per step, then RUN at cycle 32.
    expect_at(0,  F_LEDS, 4'hF, "sw_leds");
    expect_at(1,  F_LEDS, 4'hE, "sw_leds");
    expect_at(8,  F_LEDS, 4'hE, "sw_leds");
    expect_at(9,  F_LEDS, 4'hD, "sw_leds");
    expect_at(17, F_LEDS, 4'hB, "sw_leds");
    expect_at(25, F_LEDS, 4'h7, "sw_leds");
    expect_at(32, F_LEDS, 4'h7, "sw_leds");
    expect_at(31, F_DONE, 4'h0, "sw_done");
    expect_at(32, F_DONE, 4'h1, "sw_done");
    expect_at(33, F_LEDS, 4'hE, "run_hb");
    expect_at(20, F_BNC,  4'h0, "sw_bnc");
    expect_at(10, F_GND,  4'h0, "sw_gnd");
    // Idle heartbeat: hb toggles every 20 clk, leds[3:1] stay dark.
    expect_at(40, F_LEDS, 4'hE, "hb");
    expect_at(41, F_LEDS, 4'hF, "hb");
    expect_at(60, F_LEDS, 4'hF, "hb");
    expect_at(61, F_LEDS, 4'hE, "hb");
    expect_at(80, F_LEDS, 4'hE, "hb");
    expect_at(81, F_LEDS, 4'hF, "hb");
    @(posedge clk);
    #1 rst_n = 1'b1;
    goto(99);

    // Single pulse on channel 2; heartbeat is suppressed while any channel is active.
    expect_at(101, F_LEDS, 4'hE, "ev2");
    expect_at(102, F_LEDS, 4'hB, "ev2");
    expect_at(112, F_LEDS, 4'hB, "ev2");
    expect_at(113, F_LEDS, 4'hE, "ev2");
    expect_at(120, F_LEDS, 4'hE, "ev2");
    expect_at(121, F_LEDS, 4'hF, "ev2");
    expect_at(101, F_BNC, bx(4'h0), "ev2_bnc");
    expect_at(102, F_BNC, bx(4'h4), "ev2_bnc");
    expect_at(112, F_BNC, bx(4'h4), "ev2_bnc");
    expect_at(113, F_BNC, bx(4'h0), "ev2_bnc");
    goto(100); event_in = 4'b0100;
    goto(101); event_in = 4'b0000;
    goto(129);

    // Channel 1 retriggered 6 clk later, then held high without a further retrigger.
    expect_at(131, F_LEDS, 4'hF, "ev1");
    expect_at(132, F_LEDS, 4'hD, "ev1");
    expect_at(141, F_LEDS, 4'hD, "ev1");
    expect_at(148, F_LEDS, 4'hD, "ev1");
    expect_at(149, F_LEDS, 4'hE, "ev1");
    expect_at(159, F_LEDS, 4'hE, "ev1_hold");
    expect_at(145, F_BNC, bx(4'h2), "ev1_bnc");
    expect_at(149, F_BNC, bx(4'h0), "ev1_bnc");
    goto(130); event_in = 4'b0010;
    goto(131); event_in = 4'b0000;
    goto(136); event_in = 4'b0010;
    goto(160); event_in = 4'b0000;
    goto(199);

    // Channel 0 event while heartbeat is low: solid on until the stretch ends.
    expect_at(201, F_LEDS, 4'hF, "ev0");
    expect_at(202, F_LEDS, 4'hE, "ev0");
    expect_at(212, F_LEDS, 4'hE, "ev0");
    expect_at(213, F_LEDS, 4'hF, "ev0");
    expect_at(205, F_BNC, bx(4'h1), "ev0_bnc");
    expect_at(213, F_BNC, bx(4'h0), "ev0_bnc");
    goto(200); event_in = 4'b0001;
    goto(201); event_in = 4'b0000;
    goto(229);

    // Reset asserted mid-stretch on channel 3.
    expect_at(232, F_LEDS, 4'h7, "ev3");
    expect_at(232, F_BNC, bx(4'h8), "ev3_bnc");
    goto(230); event_in = 4'b1000;
    goto(231); event_in = 4'b0000;
    goto(233);
    chk("sb_drained", sb.size(), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_leds", {28'h0, leds}, 32'hF);
    chk("mid_rst_bnc", {28'h0, bnc}, 32'h0);
    chk("mid_rst_done", {31'h0, sweep_done}, 32'h0);

    // Sweep restarts; lamp test aborts it, then RUN without resuming the sweep.
    expect_at(1,  F_LEDS, 4'hE, "rs_sweep");
    expect_at(9,  F_LEDS, 4'hD, "rs_sweep");
    expect_at(12, F_DONE, 4'h0, "lt_done");
    expect_at(13, F_DONE, 4'h1, "lt_done");
    expect_at(13, F_LEDS, 4'hD, "lt_leds");
    expect_at(14, F_LEDS, 4'h0, "lt_leds");
    expect_at(20, F_LEDS, 4'h0, "lt_leds");
    expect_at(14, F_BNC,  4'h0, "lt_bnc");
    expect_at(25, F_LEDS, 4'h0, "lt_exit");
    expect_at(26, F_LEDS, 4'hE, "lt_exit");
    expect_at(34, F_LEDS, 4'hE, "lt_nosweep");
    expect_at(40, F_LEDS, 4'hE, "lt_hb");
    expect_at(41, F_LEDS, 4'hF, "lt_hb");
    expect_at(41, F_DONE, 4'h1, "lt_done");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    goto(12); test_en = 1'b1;
    goto(24); test_en = 1'b0;
    goto(45);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
